alu_exec_seq: RTL and testbench
===============================

# alu_exec_seq

Sequential execution unit on the consuming end of the 3-bit ALU control code produced by the ALU control decoder. It sits in the EX stage between the operand muxes and the result/branch logic. It accepts one operation per handshake. Single-cycle ops complete in one clock; `mul` runs as an iterative shift-add over WIDTH cycles and holds `busy_o` meanwhile. It also provides the zero flag used by `beq`.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width; also the `mul` iteration count.

Ports:
- `clk_i`, input, 1: single clock, rising-edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `start_i`, input, 1: request; accepted on a rising edge when `busy_o`=0.
- `ctl_i`, input, 3: ALU control code, sampled at accept.
- `a_i`, input, WIDTH: operand A (rs1), sampled at accept.
- `b_i`, input, WIDTH: operand B (rs2 or immediate), sampled at accept.
- `busy_o`, output, 1: high while a `mul` is iterating.
- `done_o`, output, 1: one-cycle pulse; `result_o` and `zero_o` are valid from this cycle.
- `result_o`, output, WIDTH: registered result, held until the next completion.
- `zero_o`, output, 1: registered; equals (`result_o` == 0).

## Operation
Control codes:
- 000: and, A & B.
- 001: xor, A ^ B.
- 010: add, A + B mod 2^WIDTH.
- 011: sll, A << B[4:0].
- 101: mul, low WIDTH bits of A*B.
- 110: sub, A − B mod 2^WIDTH.
- 111: srai, A >>> B[4:0], arithmetic.
- 100: reserved; result is 0, completes like a single-cycle op.

Shift rules:
- Shift amount is always B[4:0]; B[WIDTH-1:5] is ignored.
- srai replicates A[WIDTH-1].

State machine: IDLE, MUL.
- IDLE, accept, non-mul code: compute; register `result_o` and `zero_o`; `done_o`=1 next cycle; stay IDLE.
- IDLE, accept, code 101: load multiplicand = A, multiplier = B, accumulator = 0, counter = 0. Go to MUL; `busy_o`=1.
- MUL, each cycle:
  - If multiplier[0]=1, accumulator += multiplicand (mod 2^WIDTH).
  - Multiplicand <<= 1; multiplier >>= 1; counter++.
  - When counter reaches WIDTH−1 on this edge, write the final accumulator to `result_o`, set `done_o`=1 and `zero_o`, clear `busy_o`, and go to IDLE.
- `start_i` while `busy_o`=1: ignored, not queued. Operands and code changing mid-mul have no effect.
- Back-to-back: a `start_i` in the cycle `done_o` is high is accepted, since `busy_o` is already 0.
- With no accept, `done_o` returns to 0 and `result_o`/`zero_o` hold.

Reset (async, any state, including mid-mul):
- State → IDLE.
- `busy_o`=0, `done_o`=0, `result_o`=0, `zero_o`=1.
- Accumulator and counter cleared.
- The in-flight op is discarded; no `done_o` is produced for it.

## Timing
- Accept edge = edge where `start_i`=1 and `busy_o`=0.
- Non-mul latency is 1: `done_o`/`result_o` are valid in the cycle right after the accept edge.
- Mul latency is WIDTH: `busy_o` is high for WIDTH cycles after the accept edge. `done_o` and the result appear on edge accept+WIDTH, in the same edge `busy_o` falls.
- Throughput: 1 op/cycle for non-mul; 1 op per WIDTH cycles for mul.
- All outputs are registered; there is no combinational path from the inputs to the outputs.
- Release of `rst_i` is synchronous to `clk_i`. The first accept can occur on the first edge after deassertion.

## Test plan
- Reset then idle: `result_o`=0, `zero_o`=1, `busy_o`=0, `done_o`=0. Then add 5 + 7: `done_o` pulses 1 cycle later, `result_o`=12, `zero_o`=0.
- sub 0x1234 − 0x1234: `result_o`=0, `zero_o`=1. sub 0 − 1: `result_o`=0xFFFFFFFF.
- Shifts:
  - srai 0x80000000 by b=0x24 (amount 4): 0xF8000000.
  - sll 1 by 31: 0x80000000.
  - xor 0xF0F0F0F0 ^ 0xFFFF0000: 0x0F0FF0F0.
  - and of the same operands: 0xF0F00000.
- mul 0xFFFFFFFF × 3:
  - `busy_o` is high for exactly 32 cycles, then `result_o`=0xFFFFFFFD and `done_o` pulses.
  - A `start_i`/add pulse at iteration 10 is ignored, and the result is unchanged.
  - An add issued in the `done_o` cycle completes next cycle.
- `rst_i` asserted at mul iteration 15 of 6 × 7:
  - Outputs immediately return to their reset values, and no `done_o` is produced for that op.
  - After release, mul 6 × 7 gives 42 after 32 cycles.
- Reserved code 100 with A=B=0xFFFFFFFF: `result_o`=0, `zero_o`=1, 1-cycle `done_o`, `busy_o` never asserts.

Source files
------------

// File: rtl/alu_exec_seq_if.sv
// Handshake and data bundle between the EX-stage operand muxes and alu_exec_seq.
interface alu_exec_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start_i;
  logic [2:0]       ctl_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport master (
    output start_i, ctl_i, a_i, b_i,
    input  busy_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, ctl_i, a_i, b_i,
    output busy_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_exec_seq.sv
// EX-stage execution unit: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiplier; all outputs registered.
module alu_exec_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_exec_seq_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLL  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  logic [0:0]       state;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;

  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;
  assign bus.zero_o   = zero;

  always_comb begin
    shamt   = bus.b_i[4:0];
    alu_res = '0;
    case (bus.ctl_i)
      OP_AND:  alu_res = bus.a_i & bus.b_i;
      OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
      OP_ADD:  alu_res = bus.a_i + bus.b_i;
      OP_SLL:  alu_res = bus.a_i << shamt;
      OP_SUB:  alu_res = bus.a_i - bus.b_i;
      OP_SRAI: alu_res = $signed(bus.a_i) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.ctl_i == OP_MUL) begin
              mcand  <= bus.a_i;
              mplier <= bus.b_i;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_MUL;
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last step publishes acc_next directly so the result lands on accept+WIDTH.
          if (cnt == LAST) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a cycle-level reference model.
module tb_alu_exec_seq;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic chk_en;

  alu_exec_seq_if #(.WIDTH(W)) bus ();

  alu_exec_seq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    int          sh;
    sh = int'(b % 32);
    case (c)
      3'd0: r = a & b;
      3'd1: r = a ^ b;
      3'd2: r = a + b;
      3'd3: r = a << sh;
      3'd5: r = a * b;
      3'd6: r = a - b;
      3'd7: r = $signed(a) >>> sh;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reference model: mul takes W cycles of busy, everything else completes next cycle
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
      m_pend <= 32'd0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end else if (bus.start_i) begin
        if (bus.ctl_i == 3'b101) begin
          m_busy <= 1'b1;
          m_left <= W;
          m_pend <= ref_op(bus.ctl_i, bus.a_i, bus.b_i);
        end else begin
          m_res  <= ref_op(bus.ctl_i, bus.a_i, bus.b_i);
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("m_busy", {31'd0, bus.busy_o}, {31'd0, m_busy});
      chk("m_done", {31'd0, bus.done_o}, {31'd0, m_done});
      chk("m_result", bus.result_o, m_res);
      chk("m_zero", {31'd0, bus.zero_o}, {31'd0, (m_res == 32'd0)});
    end
  end

  task automatic op1(input string name, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    bus.start_i = 1'b1;
    bus.ctl_i   = c;
    bus.a_i     = a;
    bus.b_i     = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk({name, "_done"}, {31'd0, bus.done_o}, 32'd1);
    chk(name, bus.result_o, exp);
  endtask

  task automatic mul_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit inject);
    int n;
    int nbusy;
    bus.start_i = 1'b1;
    bus.ctl_i   = 3'b101;
    bus.a_i     = a;
    bus.b_i     = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    n     = 0;
    nbusy = 0;
    while (!bus.done_o && n < 40) begin
      if (bus.busy_o) nbusy++;
      if (inject && n == 10) begin
        bus.start_i = 1'b1;
        bus.ctl_i   = 3'b010;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd1;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start_i = 1'b0;
    chk({name, "_busy_cycles"}, nbusy, 32'd32);
    chk({name, "_done"}, {31'd0, bus.done_o}, 32'd1);
    chk({name, "_busy_fall"}, {31'd0, bus.busy_o}, 32'd0);
    chk(name, bus.result_o, exp);
  endtask

  initial begin
    int ndone;
    total       = 0;
    bad         = 0;
    chk_en      = 1'b0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.ctl_i   = 3'b000;
    bus.a_i     = 32'd0;
    bus.b_i     = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_zero", {31'd0, bus.zero_o}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    op1("add_5_7", 3'b010, 32'd5, 32'd7, 32'd12);
    chk("add_zero", {31'd0, bus.zero_o}, 32'd0);
    op1("sub_eq", 3'b110, 32'h1234, 32'h1234, 32'd0);
    chk("sub_eq_zero", {31'd0, bus.zero_o}, 32'd1);
    op1("sub_0_1", 3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF);
    op1("srai", 3'b111, 32'h8000_0000, 32'h24, 32'hF800_0000);
    op1("sll", 3'b011, 32'd1, 32'd31, 32'h8000_0000);
    op1("xor", 3'b001, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);
    op1("and", 3'b000, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000);
    @(negedge clk);
    chk("idle_done_low", {31'd0, bus.done_o}, 32'd0);
    chk("idle_hold", bus.result_o, 32'hF0F0_0000);

    mul_op("mul_m1x3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b1);
    op1("b2b_add", 3'b010, 32'd2, 32'd3, 32'd5);

    bus.start_i = 1'b1;
    bus.ctl_i   = 3'b101;
    bus.a_i     = 32'd6;
    bus.b_i     = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("midrst_done", {31'd0, bus.done_o}, 32'd0);
    chk("midrst_result", bus.result_o, 32'd0);
    chk("midrst_zero", {31'd0, bus.zero_o}, 32'd1);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    chk("no_done_after_rst", ndone, 32'd0);

    mul_op("mul_6x7", 32'd6, 32'd7, 32'd42, 1'b0);

    op1("reserved", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    chk("reserved_zero", {31'd0, bus.zero_o}, 32'd1);
    chk("reserved_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
